// File: rtl/and_or_arbiter.sv
// rtl/and_or_arbiter.sv - two-requester arbiter/sequencer for the shared AND/OR logic unit
// Optional round-robin conflict resolution: define AND_OR_ARB_RR_EN.
module and_or_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic   winner;
    logic   accept;

    assign accept = (state == IDLE) && (req0_valid || req1_valid);

`ifdef AND_OR_ARB_RR_EN
    // Pointer holds the most recent grant; reset to 1 so requester 0 wins the first conflict.
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end
`else
    assign winner = ~req0_valid & req1_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                alu_a   <= winner ? req1_a : req0_a;
                alu_b   <= winner ? req1_b : req0_b;
                alu_sel <= winner ? req1_sel : req0_sel;
                rsp_id  <= winner;
            end
            if (state == EXEC) begin
                rsp_data <= alu_result;
            end
        end
    end

    // Ready is masked by reset so it reads 0 while rst_n is low even with valid high.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !winner;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && winner;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: doc/and_or_arbiter.md
# and_or_arbiter

Two-requester arbiter and sequencer for the shared 32-bit AND/OR logic unit in the phase-1 datapath. It accepts operand/selection requests over valid/ready ports, chooses one requester and registers its operands onto the logic unit's inputs. It then captures the unit's combinational result and returns it, tagged with the requester ID, over a valid/ready response port. The logic unit itself stays external; this block owns its inputs.

## Interface
- WIDTH, 32, operand and result width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request pending from requester 0 / 1
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- req0_sel / req1_sel  input  1  logic-unit selection bit, forwarded unmodified
- alu_a, alu_b  output  WIDTH  registered operands to the logic unit's A and B inputs
- alu_sel  output  1  registered selection to the logic unit
- alu_result  input  WIDTH  combinational result from the logic unit
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that owns the response
- rsp_data  output  WIDTH  captured result
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE
  - If any reqN_valid is high, select a winner and assert its reqN_ready combinationally. The other requester's ready stays 0.
  - On the clock edge, load alu_a/alu_b/alu_sel from the winner and rsp_id with the winner's ID, then go to EXEC.
- EXEC
  - alu_* hold their values.
  - On the clock edge, load rsp_data with alu_result and go to RESP.
- RESP
  - rsp_valid = 1.
  - rsp_data, rsp_id and alu_* stay stable until rsp_ready = 1.
  - The handshake edge returns the FSM to IDLE.
- Ready rule: reqN_ready = (state == IDLE) & reqN_valid & (winner == N). Ready is never high outside IDLE.
- Requester obligations:
  - Hold operands stable while valid is high and ready is low.
  - Valid may drop before acceptance; a dropped request is simply not served.
- Arbitration:
  - A single valid requester always wins.
  - A conflict is resolved per Configuration.
- No bypass: a response handshake and a new request never complete in the same cycle.
- Data is passed through untouched. No width change, no arithmetic in this block.

## Timing
- Reset values: alu_a = 0, alu_b = 0, alu_sel = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, req*_ready = 0, last-grant pointer = 1 (so requester 0 wins the first conflict).
- Latency: with acceptance in cycle k, rsp_valid is high from cycle k+2.
- Throughput: one operation per 3 cycles when rsp_ready is tied high. The next acceptance is possible in cycle k+3.
- Backpressure: each cycle with rsp_ready = 0 in RESP adds one cycle. Outputs hold.
- Reset mid-operation: asserting rst_n low in EXEC or RESP aborts the transaction immediately. No response is produced, and all outputs return to their reset values asynchronously.
- The last-grant pointer updates only on the acceptance edge.

## Configuration
- AND_OR_ARB_RR_EN defined:
  - Round-robin arbitration. On a conflict, the requester not granted most recently wins.
  - The first conflict after reset goes to requester 0.
- AND_OR_ARB_RR_EN undefined:
  - Fixed priority; requester 0 always wins a conflict.
  - The pointer register is not instantiated.

## Test plan
Bench logic-unit model: sel = 0 gives A & B, sel = 1 gives A | B.
- Solo request: req0 valid with a = 7, b = 5, sel = 1, and rsp_ready = 1 -> req0_ready high in cycle k; rsp_valid with rsp_id = 0 and rsp_data = 7 in cycle k+2; busy low in cycle k+3.
- Conflict, round-robin enabled: both valid (req0: 6, 2, sel 0; req1: 7, 5, sel 1) held for two transactions -> first response id 0, data 2; second response id 1, data 7.
- Conflict, macro undefined: same stimulus with req0 re-asserted after its response -> req0 served twice before req1.
- Backpressure: rsp_ready = 0 for 4 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable for all 4 cycles; req*_ready stay 0; handshake on the 5th cycle.
- Reset mid-EXEC: rst_n pulsed low during EXEC -> all outputs 0 immediately; no rsp_valid afterward; the next request is served normally.
- Withdrawn request: req1_valid high for one cycle while busy, then low -> req1 is never granted and no id-1 response appears.
